// File: rtl/trace_compare.sv
`default_nettype none
// ============================================================================
//  Module   : trace_compare
//  Purpose  : Records the instruction-fetch address trace of two streams in
//             per-stream FIFOs and compares them entry by entry in program
//             order. It reports the first address or length divergence, and
//             raises a final verdict once the harness is finished and the
//             buffered entries are drained.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W  instruction address width
//    DEPTH   entries per trace FIFO (power of two, >= 2)
//    IDX_W   width of the compare index
//  Ports
//    clk_i              clock, rising edge
//    rst_i              synchronous active-high reset
//    fetch_1_i/2_i      fetch strobe per stream
//    instr_addr_1_i/2_i fetch address per stream
//    enable_1_i/2_i     stream enables
//    finished_i         completion flag (level, treated as sticky)
//    done_o             verdict valid, held until reset
//    mismatch_o         sticky divergence flag
//    mismatch_idx_o     0-based index of the first divergent entry
//    mismatch_addr_1_o  stream 1 address at first divergence (0 if missing)
//    mismatch_addr_2_o  stream 2 address at first divergence (0 if missing)
//    overflow_o         sticky: a capture was dropped on a full FIFO
//  Build option
//    TRACE_CMP_EARLY_EXIT_EN  when defined, the first address mismatch or
//                             overflow sends the FSM straight to DONE.
// ============================================================================
module trace_compare #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fetch_1_i,
    input  logic              fetch_2_i,
    input  logic [ADDR_W-1:0] instr_addr_1_i,
    input  logic [ADDR_W-1:0] instr_addr_2_i,
    input  logic              enable_1_i,
    input  logic              enable_2_i,
    input  logic              finished_i,
    output logic              done_o,
    output logic              mismatch_o,
    output logic [IDX_W-1:0]  mismatch_idx_o,
    output logic [ADDR_W-1:0] mismatch_addr_1_o,
    output logic [ADDR_W-1:0] mismatch_addr_2_o,
    output logic              overflow_o
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Per-stream views: index 0 is stream 1, index 1 is stream 2.
    logic [1:0]             w_req;
    logic [1:0]             w_cap;
    logic [1:0]             w_empty;
    logic [1:0]             w_full;
    logic [1:0]             w_push;
    logic [1:0]             w_drop_vec;
    logic [1:0][ADDR_W-1:0] w_addr_in;
    logic [1:0][ADDR_W-1:0] w_head;

    logic                   w_pop;
    logic                   w_drop;
    logic                   w_addr_diff;
    logic                   w_latch;
    logic                   w_set_mis;
    logic [ADDR_W-1:0]      w_lat_a1;
    logic [ADDR_W-1:0]      w_lat_a2;

    logic                   r_done;
    logic                   r_mismatch;
    logic                   r_overflow;
    logic [IDX_W-1:0]       r_idx;
    logic [IDX_W-1:0]       r_mis_idx;
    logic [ADDR_W-1:0]      r_mis_a1;
    logic [ADDR_W-1:0]      r_mis_a2;

    assign w_req     = {fetch_2_i & enable_2_i, fetch_1_i & enable_1_i};
    assign w_addr_in = {instr_addr_2_i, instr_addr_1_i};
    assign w_cap     = (r_state == ST_RUN) ? w_req : 2'b00;

    // Both heads leave together; nothing moves once the verdict is reached.
    assign w_pop       = (r_state != ST_DONE) && !w_empty[0] && !w_empty[1];
    assign w_addr_diff = w_pop && (w_head[0] != w_head[1]);
    assign w_drop      = |w_drop_vec;

    // ------------------------------------------------------------------------
    // Trace FIFOs
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [ADDR_W-1:0]  r_mem [DEPTH];
        logic [c_ptr_w-1:0] r_wr;
        logic [c_ptr_w-1:0] r_rd;
        logic [c_cnt_w-1:0] r_cnt;

        assign w_empty[g]    = (r_cnt == '0);
        assign w_full[g]     = (r_cnt == c_cnt_w'(DEPTH));
        // A simultaneous pop frees a slot for this edge's push.
        assign w_push[g]     = w_cap[g] && (!w_full[g] || w_pop);
        assign w_drop_vec[g] = w_cap[g] && w_full[g] && !w_pop;
        assign w_head[g]     = r_mem[r_rd];

        always_ff @(posedge clk_i) begin
            if (w_push[g]) begin
                r_mem[r_wr] <= w_addr_in[g];
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_wr  <= '0;
                r_rd  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push[g]) begin
                    r_wr <= r_wr + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_rd <= r_rd + c_ptr_w'(1);
                end
                if (w_push[g] && !w_pop) begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end else if (!w_push[g] && w_pop) begin
                    r_cnt <= r_cnt - c_cnt_w'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and first-divergence capture
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_lat_a1    = w_head[0];
        w_lat_a2    = w_head[1];

        if (w_addr_diff && !r_mismatch) begin
            w_latch = 1'b1;
        end

        case (r_state)
            ST_RUN: begin
                if (finished_i) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_empty[0] && w_empty[1]) begin
                    w_state_nxt = ST_DONE;
                end else if (w_empty[0] != w_empty[1]) begin
                    // One trace is longer: the missing side reports 0.
                    w_state_nxt = ST_DONE;
                    if (!r_mismatch) begin
                        w_latch  = 1'b1;
                        w_lat_a1 = w_empty[0] ? '0 : w_head[0];
                        w_lat_a2 = w_empty[1] ? '0 : w_head[1];
                    end
                end
            end
            default: begin
                w_state_nxt = ST_DONE;
            end
        endcase

`ifdef TRACE_CMP_EARLY_EXIT_EN
        if ((r_state != ST_DONE) && !r_mismatch && (w_addr_diff || w_drop)) begin
            w_state_nxt = ST_DONE;
        end
`endif

        // An overflow anywhere in the run makes the verdict a mismatch.
        w_set_mis = w_latch ||
                    ((r_state != ST_DONE) && (w_state_nxt == ST_DONE) &&
                     (r_overflow || w_drop));
    end

    // ------------------------------------------------------------------------
    // State and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_RUN;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
            r_overflow <= 1'b0;
            r_idx      <= '0;
            r_mis_idx  <= '0;
            r_mis_a1   <= '0;
            r_mis_a2   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == ST_DONE);
            if (w_set_mis) begin
                r_mismatch <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_pop && (r_idx != {IDX_W{1'b1}})) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_latch) begin
                r_mis_idx <= r_idx;
                r_mis_a1  <= w_lat_a1;
                r_mis_a2  <= w_lat_a2;
            end
        end
    end

    assign done_o            = r_done;
    assign mismatch_o        = r_mismatch;
    assign overflow_o        = r_overflow;
    assign mismatch_idx_o    = r_mis_idx;
    assign mismatch_addr_1_o = r_mis_a1;
    assign mismatch_addr_2_o = r_mis_a2;

endmodule
`default_nettype wire
